io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter CH_COUNT, default 2, number of IO channels (2..8).
REQ-002 SHALL have parameter WORD_SIZE, default 64, data width in bits.
REQ-003 SHALL have parameter ADDR_SIZE, default 64, address width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles for mem_ack; 0 disables timeout.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ch_req  input  CH_COUNT  per-channel transfer request.
REQ-008 SHALL have port ch_dir  input  CH_COUNT  per-channel direction, 1 = write to memory, 0 = read.
REQ-009 SHALL have port ch_addr  input  CH_COUNT*ADDR_SIZE  per-channel address; channel i at slice [i*ADDR_SIZE +: ADDR_SIZE].
REQ-010 SHALL have port ch_wdata  input  CH_COUNT*WORD_SIZE  per-channel write data; same slicing.
REQ-011 SHALL have port ch_rdata  output  WORD_SIZE  read data, shared, valid with ch_done.
REQ-012 SHALL have port ch_done  output  CH_COUNT  one-cycle completion pulse per channel.
REQ-013 SHALL have port ch_err  output  CH_COUNT  one-cycle timeout flag, coincident with ch_done.
REQ-014 SHALL have port mem_req / mem_we  output  1 each  memory-side request and write enable.
REQ-015 SHALL have port mem_addr / mem_wdata  output  ADDR_SIZE / WORD_SIZE  memory-side address and write data.
REQ-016 SHALL have port mem_rdata / mem_ack  input  WORD_SIZE / 1  memory-side read data and acknowledge.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port grant_idx  output  $clog2(CH_COUNT) (min 1)  index of channel currently granted.

Function
REQ-019 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; all outputs registered.
REQ-020 In IDLE with any ch_req high, SHALL grant the first requesting channel at or after rr_ptr, wrapping at CH_COUNT (round-robin).
REQ-021 On grant SHALL latch addr, wdata, dir of winner into mem_addr, mem_wdata, mem_we, set mem_req=1, grant_idx=winner, go to WAIT; mem_req rises the cycle after ch_req sampled.
REQ-022 In WAIT SHALL hold mem_req, mem_addr, mem_we, mem_wdata stable until mem_ack sampled high.
REQ-023 On mem_ack in WAIT SHALL drop mem_req, capture mem_rdata into ch_rdata if mem_we=0 (else ch_rdata unchanged), go to DONE.
REQ-024 In DONE SHALL pulse ch_done[grant_idx] for exactly one cycle, set rr_ptr=(grant_idx+1) mod CH_COUNT, return to IDLE.
REQ-025 Timeout: wait counter cleared on entry to WAIT, increments each WAIT cycle; on reaching TIMEOUT without ack SHALL drop mem_req, go to DONE, pulse ch_err and ch_done together, ch_rdata unchanged.
REQ-026 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (no ch_err).
REQ-027 mem_ack sampled in IDLE or DONE SHALL be ignored.
REQ-028 ch_req deasserted after grant SHALL NOT abort the transaction; channel still receives ch_done.
REQ-029 At most one ch_done bit high in any cycle; back-to-back grants separated by at least one IDLE cycle.
REQ-030 With all channels requesting continuously, each SHALL be granted once per CH_COUNT transactions.

Reset
REQ-031 rst high SHALL immediately force IDLE, rr_ptr=0, grant_idx=0, wait counter=0, and all outputs (mem_req, mem_we, mem_addr, mem_wdata, ch_rdata, ch_done, ch_err, busy) to 0.
REQ-032 rst asserted mid-WAIT SHALL abandon the transaction with no ch_done/ch_err pulse.
REQ-033 First grant after rst deassertion SHALL follow REQ-020 with rr_ptr=0.

Verification
REQ-034 Single read: ch_req=01, ch_addr[0]=0x10, mem_ack after 3 cycles with mem_rdata=0xDEAD -> mem_addr=0x10, mem_we=0, ch_rdata=0xDEAD, ch_done=01 one cycle.
REQ-035 Round-robin: ch_req=11 held, ack always 1 cycle -> grant sequence 0,1,0,1; no channel granted twice in a row.
REQ-036 Timeout: TIMEOUT=4, write on ch1, no ack -> mem_req low after 4 WAIT cycles, ch_done=10 and ch_err=10 same cycle, ch_rdata unchanged.
REQ-037 Ack-at-limit: TIMEOUT=4, ack on 4th WAIT cycle -> ch_done pulse, ch_err=0.
REQ-038 Reset mid-WAIT: rst during WAIT -> all outputs 0 next edge (async), no ch_done; next request on ch1 alone granted to ch1.
REQ-039 Stray ack: mem_ack=1 in IDLE with no requests -> no state change, busy=0, ch_done=0.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// Channel-side and memory-side signal bundle for the IO bus arbiter.
// The master modport is the arbiter; the slave modport is the channels plus memory.
interface io_bus_arbiter_if #(
    parameter int CH_COUNT  = 2,
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 64
);
    localparam int IDX_W = (CH_COUNT > 2) ? $clog2(CH_COUNT) : 1;

    logic [CH_COUNT-1:0]           ch_req;
    logic [CH_COUNT-1:0]           ch_dir;
    logic [CH_COUNT*ADDR_SIZE-1:0] ch_addr;
    logic [CH_COUNT*WORD_SIZE-1:0] ch_wdata;
    logic [WORD_SIZE-1:0]          ch_rdata;
    logic [CH_COUNT-1:0]           ch_done;
    logic [CH_COUNT-1:0]           ch_err;
    logic                          mem_req;
    logic                          mem_we;
    logic [ADDR_SIZE-1:0]          mem_addr;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic [WORD_SIZE-1:0]          mem_rdata;
    logic                          mem_ack;
    logic                          busy;
    logic [IDX_W-1:0]              grant_idx;

    modport master (
        input  ch_req, ch_dir, ch_addr, ch_wdata, mem_rdata, mem_ack,
        output ch_rdata, ch_done, ch_err, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_idx
    );

    modport slave (
        output ch_req, ch_dir, ch_addr, ch_wdata, mem_rdata, mem_ack,
        input  ch_rdata, ch_done, ch_err, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_idx
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter of CH_COUNT IO channels onto one memory port; mem_req one cycle after ch_req,
// held until mem_ack or TIMEOUT, then a one-cycle ch_done (and ch_err on timeout) before re-arbitrating.
module io_bus_arbiter #(
    parameter int CH_COUNT  = 2,
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    io_bus_arbiter_if.master  bus
);
    localparam int IDX_W = (CH_COUNT > 2) ? $clog2(CH_COUNT) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(CH_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state,     w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr,    w_rr_ptr_nxt;
    logic [IDX_W-1:0]      r_grant,     w_grant_nxt;
    logic [CNT_W-1:0]      r_wait_cnt,  w_wait_cnt_nxt;
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [ADDR_SIZE-1:0]  r_mem_addr,  w_mem_addr_nxt;
    logic [WORD_SIZE-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [WORD_SIZE-1:0]  r_ch_rdata,  w_ch_rdata_nxt;
    logic [CH_COUNT-1:0]   r_ch_done,   w_ch_done_nxt;
    logic [CH_COUNT-1:0]   r_ch_err,    w_ch_err_nxt;
    logic                  r_busy,      w_busy_nxt;

    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;

    // Scan channels starting at rr_ptr, wrapping past CH_COUNT-1 back to 0.
    always_comb begin
        logic [IDX_W:0] w_sum;
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(CH_COUNT))
                w_sum = w_sum - (IDX_W+1)'(CH_COUNT);
            if (!w_found && bus.ch_req[w_sum[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_nxt     = r_grant;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ch_rdata_nxt  = r_ch_rdata;
        w_ch_done_nxt   = '0;
        w_ch_err_nxt    = '0;
        w_busy_nxt      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_WAIT;
                    w_grant_nxt     = w_winner;
                    w_wait_cnt_nxt  = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.ch_dir[w_winner];
                    w_mem_addr_nxt  = bus.ch_addr[w_winner*ADDR_SIZE +: ADDR_SIZE];
                    w_mem_wdata_nxt = bus.ch_wdata[w_winner*WORD_SIZE +: WORD_SIZE];
                    w_busy_nxt      = 1'b1;
                end
            end
            S_WAIT: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (bus.mem_ack) begin
                    w_state_nxt            = S_DONE;
                    w_mem_req_nxt          = 1'b0;
                    w_ch_done_nxt[r_grant] = 1'b1;
                    if (!r_mem_we)
                        w_ch_rdata_nxt = bus.mem_rdata;
                end else if (TIMEOUT != 0 && r_wait_cnt == CNT_LAST) begin
                    w_state_nxt            = S_DONE;
                    w_mem_req_nxt          = 1'b0;
                    w_ch_done_nxt[r_grant] = 1'b1;
                    w_ch_err_nxt[r_grant]  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt  = S_IDLE;
                w_busy_nxt   = 1'b0;
                w_rr_ptr_nxt = (r_grant == CH_LAST) ? '0 : r_grant + IDX_W'(1);
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ch_rdata  <= '0;
            r_ch_done   <= '0;
            r_ch_err    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ch_rdata  <= w_ch_rdata_nxt;
            r_ch_done   <= w_ch_done_nxt;
            r_ch_err    <= w_ch_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ch_rdata  = r_ch_rdata;
    assign bus.ch_done   = r_ch_done;
    assign bus.ch_err    = r_ch_err;
    assign bus.busy      = r_busy;
    assign bus.grant_idx = r_grant;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: two channels, TIMEOUT=4, inputs driven and outputs sampled on negedge.
module tb_io_bus_arbiter;
    localparam int CH = 2;
    localparam int W  = 64;
    localparam int A  = 64;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.CH_COUNT(CH), .WORD_SIZE(W), .ADDR_SIZE(A)) bif ();

    io_bus_arbiter #(.CH_COUNT(CH), .WORD_SIZE(W), .ADDR_SIZE(A), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int ch, input logic [A-1:0] addr, input logic [W-1:0] wdata);
        bif.ch_addr[ch*A +: A]  = addr;
        bif.ch_wdata[ch*W +: W] = wdata;
    endtask

    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.ch_req = '0; bif.ch_dir = '0; bif.ch_addr = '0; bif.ch_wdata = '0;
        bif.mem_rdata = '0; bif.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bif.mem_req, bif.mem_we, bif.busy, bif.ch_done, bif.ch_err, bif.grant_idx} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: req/we/busy/done/err/grant=%b want 0",
                     {bif.mem_req, bif.mem_we, bif.busy, bif.ch_done, bif.ch_err, bif.grant_idx});
        end
        vectors++;
        if (bif.mem_addr !== '0 || bif.mem_wdata !== '0 || bif.ch_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", bif.mem_addr, bif.mem_wdata, bif.ch_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bif.busy !== 1'b0 || bif.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b mem_req=%b want 0 0", bif.busy, bif.mem_req);
        end
    endtask

    task automatic test_single_read();
        set_ch(0, 64'h10, 64'h0);
        bif.ch_dir = 2'b00; bif.mem_rdata = 64'hDEAD; bif.ch_req = 2'b01;
        @(negedge clk);
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.mem_addr !== 64'h10 || bif.mem_we !== 1'b0 ||
            bif.grant_idx !== 1'b0 || bif.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_grant: req=%b addr=%h we=%b grant=%0d busy=%b want 1 10 0 0 1",
                     bif.mem_req, bif.mem_addr, bif.mem_we, bif.grant_idx, bif.busy);
        end
        bif.ch_req = 2'b00;
        repeat (2) @(negedge clk);
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.mem_addr !== 64'h10 || bif.ch_done !== 2'b00) begin
            miscompares++;
            $display("FAIL read_hold: req=%b addr=%h done=%b want 1 10 00", bif.mem_req, bif.mem_addr, bif.ch_done);
        end
        bif.mem_ack = 1'b1;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        vectors++;
        if (bif.ch_done !== 2'b01 || bif.ch_err !== 2'b00 || bif.ch_rdata !== 64'hDEAD || bif.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL read_done: done=%b err=%b rdata=%h req=%b want 01 00 dead 0",
                     bif.ch_done, bif.ch_err, bif.ch_rdata, bif.mem_req);
        end
        @(negedge clk);
        vectors++;
        if (bif.ch_done !== 2'b00 || bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL read_pulse: done=%b busy=%b want 00 0", bif.ch_done, bif.busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev;
        logic [0:0] exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_ch(0, 64'h100, 64'h0);
        set_ch(1, 64'h200, 64'h0);
        bif.ch_dir = 2'b00; bif.ch_req = 2'b11;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            exp = 1'(k % 2);
            wait_mem_req(ok);
            vectors++;
            if (!ok || bif.grant_idx !== exp || bif.mem_addr !== (exp ? 64'h200 : 64'h100) || int'(exp) == prev) begin
                miscompares++;
                $display("FAIL rr_grant%0d: seen=%b grant=%0d addr=%h want grant %0d", k, ok, bif.grant_idx, bif.mem_addr, exp);
            end
            prev = int'(exp);
            bif.mem_rdata = 64'hA000 + 64'(k);
            bif.mem_ack = 1'b1;
            @(negedge clk);
            bif.mem_ack = 1'b0;
            vectors++;
            if (bif.ch_done !== (2'b01 << exp) || bif.ch_rdata !== 64'hA000 + 64'(k)) begin
                miscompares++;
                $display("FAIL rr_done%0d: done=%b rdata=%h want %b %h", k, bif.ch_done, bif.ch_rdata,
                         2'b01 << exp, 64'hA000 + 64'(k));
            end
            @(negedge clk);
            vectors++;
            if (bif.busy !== 1'b0 || bif.mem_req !== 1'b0 || bif.ch_done !== 2'b00) begin
                miscompares++;
                $display("FAIL rr_gap%0d: busy=%b req=%b done=%b want 0 0 00", k, bif.busy, bif.mem_req, bif.ch_done);
            end
        end
        bif.ch_req = 2'b00;
    endtask

    task automatic test_timeout_and_stray_ack();
        int n;
        set_ch(1, 64'h20, 64'h1234);
        bif.ch_dir = 2'b10; bif.mem_rdata = 64'hBEEF; bif.ch_req = 2'b10;
        @(negedge clk);
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.grant_idx !== 1'b1 || bif.mem_we !== 1'b1 ||
            bif.mem_addr !== 64'h20 || bif.mem_wdata !== 64'h1234) begin
            miscompares++;
            $display("FAIL to_grant: req=%b grant=%0d we=%b addr=%h wdata=%h want 1 1 1 20 1234",
                     bif.mem_req, bif.grant_idx, bif.mem_we, bif.mem_addr, bif.mem_wdata);
        end
        bif.ch_req = 2'b00;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bif.mem_req) break;
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL to_cycles: mem_req high %0d cycles want 4", n);
        end
        vectors++;
        if (bif.ch_done !== 2'b10 || bif.ch_err !== 2'b10 || bif.ch_rdata !== 64'hA003) begin
            miscompares++;
            $display("FAIL to_done: done=%b err=%b rdata=%h want 10 10 a003", bif.ch_done, bif.ch_err, bif.ch_rdata);
        end
        bif.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bif.busy !== 1'b0 || bif.mem_req !== 1'b0 || bif.ch_done !== 2'b00 ||
                bif.ch_err !== 2'b00 || bif.ch_rdata !== 64'hA003) begin
                miscompares++;
                $display("FAIL stray_ack%0d: busy=%b req=%b done=%b err=%b rdata=%h want 0 0 00 00 a003",
                         i, bif.busy, bif.mem_req, bif.ch_done, bif.ch_err, bif.ch_rdata);
            end
        end
        bif.mem_ack = 1'b0;
    endtask

    task automatic test_ack_at_limit();
        set_ch(0, 64'h40, 64'h0);
        bif.ch_dir = 2'b00; bif.mem_rdata = 64'h5555; bif.ch_req = 2'b01;
        @(negedge clk);
        bif.ch_req = 2'b00;
        repeat (3) @(negedge clk);
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.grant_idx !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_wait: req=%b grant=%0d want 1 0", bif.mem_req, bif.grant_idx);
        end
        bif.mem_ack = 1'b1;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        vectors++;
        if (bif.ch_done !== 2'b01 || bif.ch_err !== 2'b00 || bif.ch_rdata !== 64'h5555) begin
            miscompares++;
            $display("FAIL limit_done: done=%b err=%b rdata=%h want 01 00 5555", bif.ch_done, bif.ch_err, bif.ch_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        set_ch(1, 64'h80, 64'hCAFE);
        bif.ch_dir = 2'b10; bif.ch_req = 2'b10;
        @(negedge clk);
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.grant_idx !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_grant: req=%b grant=%0d want 1 1", bif.mem_req, bif.grant_idx);
        end
        bif.ch_req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({bif.mem_req, bif.mem_we, bif.busy, bif.ch_done, bif.ch_err, bif.grant_idx} !== 8'h00 ||
            bif.mem_addr !== '0 || bif.mem_wdata !== '0 || bif.ch_rdata !== '0) begin
            miscompares++;
            $display("FAIL mid_async: ctrl=%b addr=%h wdata=%h rdata=%h want all 0",
                     {bif.mem_req, bif.mem_we, bif.busy, bif.ch_done, bif.ch_err, bif.grant_idx},
                     bif.mem_addr, bif.mem_wdata, bif.ch_rdata);
        end
        @(negedge clk);
        vectors++;
        if (bif.ch_done !== 2'b00 || bif.ch_err !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_nodone: done=%b err=%b want 00 00", bif.ch_done, bif.ch_err);
        end
        rst = 1'b0;
        set_ch(0, 64'h100, 64'h0);
        bif.ch_dir = 2'b00; bif.ch_req = 2'b11;
        @(negedge clk);
        bif.ch_req = 2'b00;
        vectors++;
        if (bif.mem_req !== 1'b1 || bif.grant_idx !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_regrant: req=%b grant=%0d want 1 0", bif.mem_req, bif.grant_idx);
        end
        bif.mem_ack = 1'b1;
        @(negedge clk);
        bif.mem_ack = 1'b0;
        vectors++;
        if (bif.ch_done !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_done: done=%b want 01", bif.ch_done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout_and_stray_ack();
        test_ack_at_limit();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
